sub64_seq: RTL and testbench
============================

// Module: sub64_seq
// PURPOSE
//  Multi-cycle unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), one CHUNK-bit slice per clock.
//  Reverse-direction companion to the combinational ripple adder in the GF multiplier datapath.
//  Used for operand range checks / modular correction on the 64-bit bus.
//  Valid/ready on both sides; one operation in flight.
// PARAMETERS
//  WIDTH  64  operand/result width; must be a multiple of CHUNK
//  CHUNK  16  bits resolved per cycle; NCHUNK = WIDTH/CHUNK (default 4)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      operands a, b, bin valid
//  in_ready    out  1      block can accept operands
//  a           in   WIDTH  minuend
//  b           in   WIDTH  subtrahend
//  bin         in   1      borrow in
//  out_valid   out  1      diff/borrow_out valid
//  out_ready   in   1      consumer takes result
//  diff        out  WIDTH  a - b - bin, modulo 2^WIDTH
//  borrow_out  out  1      1 iff a < b + bin (unsigned)
//  ovf         out  1      signed overflow (present only with SUB64_SIGNED_OVF_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0, ovf=0, chunk idx=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. in_valid&&in_ready at an edge: latch a, b; borrow reg <= bin; idx <= 0; go RUN.
//  RUN: in_ready=0. Each edge: {c,d} = a[idx] + ~b[idx] + ~borrow (CHUNK-bit slices).
//    diff slice idx <= d; borrow <= ~c; idx <= idx+1.
//    At idx==NCHUNK-1: go DONE; borrow_out <= ~c.
//  DONE: out_valid=1; diff/borrow_out stable until accepted. out_valid&&out_ready: go IDLE, out_valid drops next cycle.
//  Latency: out_valid high NCHUNK edges after the accept edge (4 at default).
//    Min issue interval NCHUNK+2 cycles.
//  No accept outside IDLE; in_valid ignored in RUN/DONE (operands held by producer).
//  out_ready ignored when out_valid=0.
//  diff undefined-but-deterministic during RUN; observe only with out_valid.
//  Wrap-around: a<b wraps mod 2^WIDTH, borrow_out=1. a==b, bin=1 gives all-ones, borrow_out=1.
//  Reset mid-RUN or mid-DONE aborts; result discarded, reset values above.
// CONFIGURATION
//  SUB64_SIGNED_OVF_EN defined:
//    ovf port exists; in DONE, ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), registered with borrow_out.
//  Undefined: ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/DONE), default WIDTH/CHUNK constants, idx width = $clog2(NCHUNK).
//  One sub-module: sub_chunk (combinational CHUNK-bit a + ~b + ~borrow_in -> d, carry), instanced once.
//    Chunk slices selected by idx.
//  Top holds FSM, operand regs, borrow reg, result reg.
// TESTING
//  Reset release, idle 3 cycles -> in_ready=1, out_valid=0, diff=0, borrow_out=0.
//  a=0x10, b=0x3, bin=0 -> after 4 edges out_valid=1, diff=0xD, borrow_out=0.
//  a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow_out=1. a=5, b=5, bin=1 -> same result.
//  Borrow across chunks: a=0x1_0000_0000_0000, b=1 -> diff=0x0000_FFFF_FFFF_FFFF, borrow_out=0.
//  Hold out_ready=0 for 5 cycles in DONE with new in_valid pulses -> result stable, in_ready=0, nothing accepted.
//    Then out_ready=1 -> IDLE, next op accepted.
//  rst_n low during RUN (idx=2) -> immediate reset values.
//    Next op a=7, b=2 -> diff=5. With SUB64_SIGNED_OVF_EN: a=0x8000_0000_0000_0000, b=1 -> ovf=1.

Source files
------------

// File: rtl/sub64_seq_pkg.sv
// Shared definitions for the sequential chunked subtractor (sub64_seq).
//   - FSM state encoding (idle / run / done)
//   - default operand width and chunk size
//   - helper that sizes the chunk index counter
// No ports; imported by sub64_seq and sub64_seq_sub_chunk.
package sub64_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 64;
    localparam int unsigned CHUNK_DEF  = 16;
    localparam int unsigned NCHUNK_DEF = WIDTH_DEF / CHUNK_DEF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Index width is $clog2(nchunk), kept at least one bit so a single-chunk
    // build still has a legal counter.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/sub64_seq_sub_chunk.sv
// Combinational CHUNK-bit subtract slice for sub64_seq.
// Computes {carry, d} = a + ~b + ~borrow_in, i.e. a - b - borrow_in in two's
// complement form; borrow out of the slice is ~carry.
// Ports:
//   a          in   CHUNK  minuend slice
//   b          in   CHUNK  subtrahend slice
//   borrow_in  in   1      borrow from the previous (lower) slice
//   d          out  CHUNK  difference slice
//   carry      out  1      carry out of a + ~b + ~borrow_in (borrow = ~carry)
module sub64_seq_sub_chunk
    import sub64_seq_pkg::*;
#(
    parameter int unsigned CHUNK = CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] d,
    output logic             carry
);

    logic [CHUNK:0] sum;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~borrow_in};
        d     = sum[CHUNK-1:0];
        carry = sum[CHUNK];
    end

endmodule

// File: rtl/sub64_seq.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), resolving
// one CHUNK-bit slice per clock through a single shared sub-chunk slice.
// One operation in flight; valid/ready handshake on input and output.
// Optional feature macro: SUB64_SIGNED_OVF_EN adds the ovf output (signed
// overflow of the subtraction, registered alongside borrow_out).
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      operands a, b, bin valid
//   in_ready    out  1      block can accept operands (idle)
//   a           in   WIDTH  minuend
//   b           in   WIDTH  subtrahend
//   bin         in   1      borrow in
//   out_valid   out  1      diff / borrow_out valid
//   out_ready   in   1      consumer takes result
//   diff        out  WIDTH  a - b - bin modulo 2^WIDTH
//   borrow_out  out  1      1 iff a < b + bin (unsigned)
//   ovf         out  1      signed overflow (only with SUB64_SIGNED_OVF_EN)
module sub64_seq
    import sub64_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB64_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || NCHUNK == 0) begin : g_bad_cfg
        $error("sub64_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              load;
`ifdef SUB64_SIGNED_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0]  a_sl, b_sl, d_sl;
    logic              c_sl;

    // Operand slice select for the current chunk index.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    sub64_seq_sub_chunk #(
        .CHUNK(CHUNK)
    ) u_sub_chunk (
        .a         (a_sl),
        .b         (b_sl),
        .borrow_in (borrow_q),
        .d         (d_sl),
        .carry     (c_sl)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SUB64_SIGNED_OVF_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        diff_d[i*CHUNK +: CHUNK] = d_sl;
                    end
                end
                borrow_d = ~c_sl;
                idx_d    = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                    idx_d   = '0;
                    bout_d  = ~c_sl;
`ifdef SUB64_SIGNED_OVF_EN
                    // diff_d already carries the top slice written this cycle.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            idx_q    <= '0;
`ifdef SUB64_SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            idx_q    <= idx_d;
`ifdef SUB64_SIGNED_OVF_EN
            ovf_q    <= ovf_d;
`endif
            if (load) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef SUB64_SIGNED_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_sub64_seq.sv
// Self-checking bench for sub64_seq: directed cases plus randomized operands,
// expected results from an arithmetic reference model pushed into a scoreboard
// queue and popped by an independent output monitor.
module tb_sub64_seq;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB64_SIGNED_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    sub64_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB64_SIGNED_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    // Reference: plain wide arithmetic, signed range check for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
        exp_t e;
        logic [W:0] r;
        logic signed [W+1:0] s, smax, smin;
        r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        s    = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y})
             - $signed({{(W+1){1'b0}}, bi});
        smax = $signed({3'b000, {(W-1){1'b1}}});
        smin = $signed({3'b111, {(W-1){1'b0}}});
        e.diff   = r[W-1:0];
        e.borrow = r[W];
        e.ovf    = (s > smax) || (s < smin);
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Monitor: every completed output handshake is compared with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=%h want=none", diff);
                end else begin
                    e = sb.pop_front();
                    chk("diff", diff, e.diff);
                    chkb("borrow_out", borrow_out, e.borrow);
`ifdef SUB64_SIGNED_OVF_EN
                    chkb("ovf", ovf, e.ovf);
`endif
                end
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_ready(input bit rnd, input logic val);
        @(posedge clk);
        #2;
        rand_ready = rnd;
        out_ready  = val;
    endtask

    // Present one operation; returns at accept edge + 1.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                        input bit track, input bit lat_chk);
        int n;
        @(posedge clk);
        #1;
        a = x;
        b = y;
        bin = bi;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout got=no_accept want=accept");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (track) sb.push_back(model(x, y, bi));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        bin = 1'($urandom_range(0, 1));
        if (lat_chk) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("latency", 64'(n), 64'd4);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] x, y;
        int n;

        // Reset release then idle.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_out_valid", out_valid, 1'b0);
        chk("rst_diff", diff, '0);
        chkb("rst_borrow_out", borrow_out, 1'b0);
`ifdef SUB64_SIGNED_OVF_EN
        chkb("rst_ovf", ovf, 1'b0);
`endif

        // Directed cases.
        set_ready(1'b0, 1'b1);
        send(64'h10, 64'h3, 1'b0, 1'b1, 1'b1);
        send(64'h0, 64'h1, 1'b0, 1'b1, 1'b0);
        send(64'h5, 64'h5, 1'b1, 1'b1, 1'b0);
        send(64'h0001_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b0);
        drain();

        // Hold result in DONE while new operands are offered.
        set_ready(1'b0, 1'b0);
        x = 64'h1234_5678_9ABC_DEF0;
        y = 64'hFEDC_BA98_7654_3210;
        e = model(x, y, 1'b1);
        send(x, y, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chkb("hold_reached_done", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(negedge clk);
            chkb("hold_in_ready", in_ready, 1'b0);
            chkb("hold_out_valid", out_valid, 1'b1);
            chk("hold_diff", diff, e.diff);
            chkb("hold_borrow", borrow_out, e.borrow);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(e);
        out_ready = 1'b1;
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        drain();

        // Reset while in RUN at chunk index 2.
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chkb("abort_in_ready", in_ready, 1'b1);
        chkb("abort_out_valid", out_valid, 1'b0);
        chk("abort_diff", diff, '0);
        chkb("abort_borrow_out", borrow_out, 1'b0);
        #2 rst_n = 1'b1;
        send(64'h7, 64'h2, 1'b0, 1'b1, 1'b1);
`ifdef SUB64_SIGNED_OVF_EN
        send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b0);
`endif
        drain();

        // Randomized traffic with random backpressure.
        set_ready(1'b1, 1'b1);
        for (int i = 0; i < 150; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: y = x;
                1: x = '0;
                2: y = x + 64'd1;
                3: begin
                    x = 64'($urandom_range(0, 15));
                    y = 64'($urandom_range(0, 15));
                end
                default: ;
            endcase
            send(x, y, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        set_ready(1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
